// File: rtl/tftp_pkg.sv
// Purpose: shared CRC-32 constants, TFTP port number and filename FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tftp_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
  localparam logic [15:0] TFTP_PORT    = 16'd69;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NAME   = 2'd1,
    LOOKUP = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Index width for an n-entry table; a single entry still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filename_lookup_if.sv
// Purpose: filename byte stream in, lookup result out, for filename_lookup.
// Latency: n/a (wiring only).
// Backpressure: none; the byte source paces itself with en.
interface filename_lookup_if
  import tftp_pkg::*;
#(
  parameter int NUM_FILES = 4,
  parameter int ADDR_W    = 16
);
  localparam int IDX_W = idx_width(NUM_FILES);

  logic              start;
  logic              en;
  logic [7:0]        eth_data;
  logic [15:0]       dest_port;
  logic              busy;
  logic              done;
  logic              hit;
  logic [IDX_W-1:0]  file_index;
  logic [ADDR_W-1:0] mem_location;
  logic              too_long;
  logic              port_ok;

  modport master (
    output start, en, eth_data, dest_port,
    input  busy, done, hit, file_index, mem_location, too_long, port_ok
  );

  modport slave (
    input  start, en, eth_data, dest_port,
    output busy, done, hit, file_index, mem_location, too_long, port_ok
  );

endinterface

// File: rtl/crc32_byte.sv
// Purpose: next reflected CRC-32 state after folding in one byte (LSB first).
// Latency: combinational.
// Backpressure: none.
module crc32_byte
  import tftp_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  logic [31:0] w_acc;

  // Eight shift/conditional-xor steps of the reflected polynomial.
  always_comb begin
    w_acc = i_crc ^ {24'd0, i_byte};
    for (int i = 0; i < 8; i++) begin
      w_acc = w_acc[0] ? ((w_acc >> 1) ^ CRC32_POLY) : (w_acc >> 1);
    end
    o_crc = w_acc;
  end

endmodule

// File: rtl/filename_lookup.sv
// Purpose: CRC-32 a NUL-terminated TFTP filename and match it against a table.
// Latency: NUL at edge k -> done/results during cycle k+2; overlong byte -> done at k+1.
// Backpressure: none; bytes are consumed whenever en is high, en=0 cycles are gaps.
module filename_lookup
  import tftp_pkg::*;
#(
  parameter int                          NUM_FILES    = 4,
  parameter int                          MAX_NAME_LEN = 64,
  parameter int                          ADDR_W       = 16,
  parameter logic [NUM_FILES*32-1:0]     FILE_CRCS    = '0,
  parameter logic [NUM_FILES*ADDR_W-1:0] FILE_LOCS    = '0,
  parameter logic [15:0]                 SERVER_PORT  = TFTP_PORT
) (
  input  logic             clk,
  input  logic             reset,
  filename_lookup_if.slave bus
);

  localparam int              IDX_W     = idx_width(NUM_FILES);
  localparam int              CNT_W     = $clog2(MAX_NAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_NAME_LEN);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_crc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_hit;
  logic              r_too_long;
  logic              r_port_ok;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_loc;

  logic              w_restart;
  logic              w_byte_nul;
  logic              w_take;
  logic              w_end_lookup;
  logic              w_end_long;
  logic [31:0]       w_crc_base;
  logic [31:0]       w_crc_next;
  logic [31:0]       w_crc_final;
  logic [NUM_FILES-1:0] w_match;
  logic              w_found;
  logic [IDX_W-1:0]  w_found_idx;
  logic [ADDR_W-1:0] w_found_loc;

  // A start byte is accepted in every state and always begins a fresh name.
  assign w_restart   = bus.start & bus.en;
  assign w_byte_nul  = (bus.eth_data == 8'h00);
  assign w_crc_base  = w_restart ? CRC32_INIT : r_crc;
  assign w_crc_final = r_crc ^ CRC32_XOROUT;

  crc32_byte u_crc (
    .i_crc  (w_crc_base),
    .i_byte (bus.eth_data),
    .o_crc  (w_crc_next)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus the per-cycle datapath strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_take       = 1'b0;
    w_end_lookup = 1'b0;
    w_end_long   = 1'b0;
    if (w_restart) begin
      // An empty name (NUL start byte) skips straight to the lookup.
      w_state_nxt = w_byte_nul ? LOOKUP : NAME;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        NAME: begin
          if (bus.en) begin
            if (w_byte_nul) begin
              w_state_nxt = LOOKUP;
            end else if (r_cnt == CNT_LIMIT) begin
              w_state_nxt = DONE;
              w_end_long  = 1'b1;
            end else begin
              w_take = 1'b1;
            end
          end
        end
        LOOKUP: begin
          w_state_nxt  = DONE;
          w_end_lookup = 1'b1;
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Running CRC and saturating byte count; NUL bytes never reach the CRC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crc <= CRC32_INIT;
      r_cnt <= '0;
    end else if (w_restart) begin
      r_crc <= w_byte_nul ? CRC32_INIT : w_crc_next;
      r_cnt <= w_byte_nul ? '0 : CNT_W'(1);
    end else if (w_take) begin
      r_crc <= w_crc_next;
      r_cnt <= (r_cnt == CNT_LIMIT) ? r_cnt : r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_FILES; g++) begin : g_cmp
    assign w_match[g] = (FILE_CRCS[32*g +: 32] == w_crc_final);
  end

  // Priority encode the matches, lowest index wins; an empty name never hits.
  always_comb begin
    w_found     = 1'b0;
    w_found_idx = '0;
    w_found_loc = '0;
    for (int i = NUM_FILES - 1; i >= 0; i--) begin
      if (w_match[i] && (r_cnt != '0)) begin
        w_found     = 1'b1;
        w_found_idx = IDX_W'(i);
        w_found_loc = FILE_LOCS[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // Results load only on entry to DONE and hold until the next DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit      <= 1'b0;
      r_idx      <= '0;
      r_loc      <= '0;
      r_too_long <= 1'b0;
    end else if (w_end_lookup) begin
      r_hit      <= w_found;
      r_idx      <= w_found_idx;
      r_loc      <= w_found_loc;
      r_too_long <= 1'b0;
    end else if (w_end_long) begin
      r_hit      <= 1'b0;
      r_idx      <= '0;
      r_loc      <= '0;
      r_too_long <= 1'b1;
    end
  end

  // Port check is captured with the start byte and held until the next start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_port_ok <= 1'b0;
    else if (w_restart) r_port_ok <= (bus.dest_port == SERVER_PORT);
  end

  assign bus.busy         = (r_state == NAME) || (r_state == LOOKUP);
  assign bus.done         = (r_state == DONE);
  assign bus.hit          = r_hit;
  assign bus.file_index   = r_idx;
  assign bus.mem_location = r_loc;
  assign bus.too_long     = r_too_long;
  assign bus.port_ok      = r_port_ok;

endmodule

// File: tb/tb_filename_lookup.sv
// Bench: three filename_lookup instances with different tables/limits share one stimulus;
// expected results are queued per instance as each terminating byte is driven.
// Outputs are sampled on the falling clock edge.
module tb_filename_lookup;

  localparam logic [127:0] CRCS_A = {32'h00000000, 32'h00000000, 32'hCBF43926, 32'h352441C2};
  localparam logic [63:0]  LOCS_A = {16'h0C00, 16'h0800, 16'h0400, 16'h0100};
  localparam logic [127:0] CRCS_B = {32'h22222222, 32'hCBF43926, 32'h11111111, 32'hCBF43926};
  localparam logic [63:0]  LOCS_B = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
  localparam logic [63:0]  CRCS_C = {32'h352441C2, 32'hCBF43926};
  localparam logic [31:0]  LOCS_C = {16'h5555, 16'hAAAA};

  typedef struct {
    logic        busy;
    logic        done;
    logic        hit;
    logic [3:0]  idx;
    logic [15:0] loc;
    logic        tl;
    logic        pok;
  } obs_t;

  typedef struct {
    logic        hit;
    logic [3:0]  idx;
    logic [15:0] loc;
    logic        tl;
    logic        pok;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  exp_t       sb [3][$];
  logic [7:0] name_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  filename_lookup_if #(.NUM_FILES(4), .ADDR_W(16)) if_a ();
  filename_lookup_if #(.NUM_FILES(4), .ADDR_W(16)) if_b ();
  filename_lookup_if #(.NUM_FILES(2), .ADDR_W(16)) if_c ();

  filename_lookup #(.NUM_FILES(4), .MAX_NAME_LEN(64), .ADDR_W(16),
                    .FILE_CRCS(CRCS_A), .FILE_LOCS(LOCS_A), .SERVER_PORT(16'd69))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  filename_lookup #(.NUM_FILES(4), .MAX_NAME_LEN(64), .ADDR_W(16),
                    .FILE_CRCS(CRCS_B), .FILE_LOCS(LOCS_B), .SERVER_PORT(16'd69))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));
  filename_lookup #(.NUM_FILES(2), .MAX_NAME_LEN(8), .ADDR_W(16),
                    .FILE_CRCS(CRCS_C), .FILE_LOCS(LOCS_C), .SERVER_PORT(16'd69))
    dut_c (.clk(clk), .reset(reset), .bus(if_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic e, input logic [7:0] d, input logic [15:0] p);
    if_a.start = s; if_a.en = e; if_a.eth_data = d; if_a.dest_port = p;
    if_b.start = s; if_b.en = e; if_b.eth_data = d; if_b.dest_port = p;
    if_c.start = s; if_c.en = e; if_c.eth_data = d; if_c.dest_port = p;
  endtask

  function automatic obs_t get_obs(input int k);
    obs_t o;
    case (k)
      0: begin
        o.busy = if_a.busy; o.done = if_a.done; o.hit = if_a.hit; o.idx = 4'(if_a.file_index);
        o.loc = if_a.mem_location; o.tl = if_a.too_long; o.pok = if_a.port_ok;
      end
      1: begin
        o.busy = if_b.busy; o.done = if_b.done; o.hit = if_b.hit; o.idx = 4'(if_b.file_index);
        o.loc = if_b.mem_location; o.tl = if_b.too_long; o.pok = if_b.port_ok;
      end
      default: begin
        o.busy = if_c.busy; o.done = if_c.done; o.hit = if_c.hit; o.idx = 4'(if_c.file_index);
        o.loc = if_c.mem_location; o.tl = if_c.too_long; o.pok = if_c.port_ok;
      end
    endcase
    return o;
  endfunction

  function automatic int max_len(input int k);
    return (k == 2) ? 8 : 64;
  endfunction

  function automatic int nfiles(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] tab_crc(input int k, input int i);
    case (k)
      0:       return CRCS_A[32*i +: 32];
      1:       return CRCS_B[32*i +: 32];
      default: return CRCS_C[32*i +: 32];
    endcase
  endfunction

  function automatic logic [15:0] tab_loc(input int k, input int i);
    case (k)
      0:       return LOCS_A[16*i +: 16];
      1:       return LOCS_B[16*i +: 16];
      default: return LOCS_C[16*i +: 16];
    endcase
  endfunction

  // Reference CRC-32 (reflected), one data bit at a time.
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic analyze(input int k, output int endp, output logic tl, output logic [31:0] crc,
                         output int nb);
    endp = -1; tl = 1'b0; crc = 32'hFFFFFFFF; nb = 0;
    for (int i = 0; i < name_q.size(); i++) begin
      if (name_q[i] == 8'h00) begin endp = i; break; end
      if (nb == max_len(k)) begin endp = i; tl = 1'b1; break; end
      crc = crc_step(crc, name_q[i]);
      nb++;
    end
    crc = ~crc;
  endtask

  task automatic lookup(input int k, input logic [31:0] crc, input int nb, output logic hit,
                        output logic [3:0] idx, output logic [15:0] loc);
    hit = 1'b0; idx = 4'd0; loc = 16'd0;
    if (nb > 0) begin
      for (int i = nfiles(k) - 1; i >= 0; i--) begin
        if (tab_crc(k, i) == crc) begin hit = 1'b1; idx = 4'(i); loc = tab_loc(k, i); end
      end
    end
  endtask

  task automatic load(input string s, input bit nul);
    name_q.delete();
    for (int i = 0; i < s.len(); i++) name_q.push_back(s[i]);
    if (nul) name_q.push_back(8'h00);
  endtask

  // Drive name_q (first byte with start) and queue each instance's expected result.
  task automatic send(input bit gaps, input logic [15:0] port);
    int          endp [3];
    logic        tl [3];
    logic [31:0] crc [3];
    int          nb [3];
    exp_t        e;
    obs_t        o;
    for (int k = 0; k < 3; k++) analyze(k, endp[k], tl[k], crc[k], nb[k]);
    for (int i = 0; i < name_q.size(); i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(posedge clk); #1;
          drive(1'b0, 1'b0, 8'($urandom), port);
        end
      end
      @(posedge clk); #1;
      if (i == 1 && endp[0] >= 1) begin
        o = get_obs(0);
        chk("busy_in_name", 32'(o.busy), 32'd1);
      end
      drive(i == 0, 1'b1, name_q[i], port);
      for (int k = 0; k < 3; k++) begin
        if (endp[k] == i) begin
          if (tl[k]) begin
            e.hit = 1'b0; e.idx = 4'd0; e.loc = 16'd0;
          end else begin
            lookup(k, crc[k], nb[k], e.hit, e.idx, e.loc);
          end
          e.tl  = tl[k];
          e.pok = (port == 16'd69);
          e.cyc = cyc + (tl[k] ? 1 : 2);
          sb[k].push_back(e);
        end
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, port);
  endtask

  task automatic check_all_zero(input string tag);
    obs_t o;
    for (int k = 0; k < 3; k++) begin
      o = get_obs(k);
      chk($sformatf("%s_busy[%0d]", tag, k), 32'(o.busy), 32'd0);
      chk($sformatf("%s_done[%0d]", tag, k), 32'(o.done), 32'd0);
      chk($sformatf("%s_hit[%0d]", tag, k), 32'(o.hit), 32'd0);
      chk($sformatf("%s_idx[%0d]", tag, k), 32'(o.idx), 32'd0);
      chk($sformatf("%s_loc[%0d]", tag, k), 32'(o.loc), 32'd0);
      chk($sformatf("%s_toolong[%0d]", tag, k), 32'(o.tl), 32'd0);
      chk($sformatf("%s_portok[%0d]", tag, k), 32'(o.pok), 32'd0);
    end
  endtask

  // Scoreboard: every done pulse pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        obs_t o;
        exp_t e;
        o = get_obs(k);
        if (o.done) begin
          if (sb[k].size() == 0) begin
            chk($sformatf("unexpected_done[%0d]", k), 32'(o.done), 32'd0);
          end else begin
            e = sb[k].pop_front();
            chk($sformatf("done_cycle[%0d]", k), 32'(cyc), 32'(e.cyc));
            chk($sformatf("hit[%0d]", k), 32'(o.hit), 32'(e.hit));
            chk($sformatf("file_index[%0d]", k), 32'(o.idx), 32'(e.idx));
            chk($sformatf("mem_location[%0d]", k), 32'(o.loc), 32'(e.loc));
            chk($sformatf("too_long[%0d]", k), 32'(o.tl), 32'(e.tl));
            chk($sformatf("port_ok[%0d]", k), 32'(o.pok), 32'(e.pok));
            chk($sformatf("busy_at_done[%0d]", k), 32'(o.busy), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 16'd69);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reference name: A hits entry 1, B resolves duplicate entries to 0, C overflows at byte 9.
    load("123456789", 1'b1); send(1'b0, 16'd69);
    // Back-to-back names, wrong port.
    load("abc", 1'b1);       send(1'b0, 16'd70);
    load("hello.bin", 1'b1); send(1'b0, 16'd69);
    // Same reference name with random en gaps.
    load("123456789", 1'b1); send(1'b1, 16'd69);
    load("abc", 1'b1);       send(1'b1, 16'd69);
    // Empty name: A holds zero-CRC entries but must still miss.
    load("", 1'b1);          send(1'b0, 16'd69);
    // Aborted name followed by a restart: only the second name completes.
    load("12345", 1'b0);     send(1'b0, 16'd69);
    load("abc", 1'b1);       send(1'b0, 16'd69);
    // Name of exactly 8 bytes fits in C's limit.
    load("abcdefgh", 1'b1);  send(1'b1, 16'd70);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a name clears every output at once.
    load("9876", 1'b0);      send(1'b0, 16'd69);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    load("123456789", 1'b1); send(1'b0, 16'd69);

    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("pending_results[%0d]", k), 32'(sb[k].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/filename_lookup.md
# filename_lookup

Parametrised TFTP filename matcher for the RX decoder path. It takes the NUL-terminated filename bytes of a read request, computes a CRC-32 over them and compares the result against a table of `NUM_FILES` served files. It returns a hit flag, the matching file index, its memory location and a destination-port check. It replaces the single-file decoder with a multi-file, length-guarded, handshaked version.

## Interface
- `NUM_FILES`, 4: number of table entries (1–16).
- `MAX_NAME_LEN`, 64: maximum non-NUL filename bytes accepted.
- `ADDR_W`, 16: memory location width.
- `FILE_CRCS`, all zero: `NUM_FILES*32` bits; entry i is at `[32*i +: 32]`.
- `FILE_LOCS`, all zero: `NUM_FILES*ADDR_W` bits; entry i is at `[ADDR_W*i +: ADDR_W]`.
- `SERVER_PORT`, 16'd69: UDP port the request must target.

Ports:
- `clk` in 1: single clock domain, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: marks the first filename byte; only meaningful while `en`=1.
- `en` in 1: `eth_data` holds a valid filename byte this cycle.
- `eth_data` in 8: filename byte.
- `dest_port` in 16: UDP destination port of the current frame; stable from `start` until `done`.
- `busy` out 1: high in NAME and LOOKUP.
- `done` out 1: one-cycle pulse when results update.
- `hit` out 1: filename matched a table entry.
- `file_index` out `$clog2(NUM_FILES)` (min 1): index of the matching entry.
- `mem_location` out `ADDR_W`: `FILE_LOCS` of the match; 0 on a miss.
- `too_long` out 1: name exceeded `MAX_NAME_LEN` without a NUL.
- `port_ok` out 1: `dest_port == SERVER_PORT`, sampled on the `start` byte.

## Operation
- State machine:
  - IDLE → NAME on `start & en`.
  - NAME → LOOKUP on a NUL byte.
  - NAME → DONE when the byte count reaches `MAX_NAME_LEN` and the next `en` byte is non-NUL.
  - LOOKUP → DONE.
  - DONE → IDLE.
- The `start` byte is itself processed as the first filename byte. It may be NUL, which gives an empty name.
- CRC-32, reflected: poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, one byte per `en` cycle. NUL bytes are excluded from the CRC.
- The byte counter is `$clog2(MAX_NAME_LEN+1)` bits and saturates. It cannot wrap.
- `en`=0 cycles in NAME are gaps: CRC and count hold.
- LOOKUP compares the final CRC against all entries in parallel. The lowest matching index wins.
- An empty name is always a miss, even if some entry's CRC equals 0x00000000.
- Too-long path: `too_long`=1, `hit`=0, `mem_location`=0, `file_index`=0.
- `start & en` in NAME, LOOKUP or DONE aborts the current name, restarts with this byte as the first byte, and produces no `done` for the aborted name.
- Bytes with `en` in IDLE without `start` are ignored.
- Result outputs (`hit`, `file_index`, `mem_location`, `too_long`) are registered in DONE and held until the next DONE.
- `port_ok` is registered on `start` and held until the next `start`.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, CRC 0xFFFFFFFF, count 0, and every output 0. This holds even mid-name; after reset release the next name starts cleanly.
- Latency: NUL accepted at edge k → LOOKUP during cycle k+1 → results valid and `done`=1 during cycle k+2 → IDLE at k+3.
- Too-long: offending byte at edge k → `done` during cycle k+1.
- Back-to-back: a `start` in the `done` cycle is accepted with no bubble.
- `busy` falls in the DONE cycle.

## Structure
- Shared package `tftp_pkg`: `CRC32_POLY`, `CRC32_INIT`, `CRC32_XOROUT`, `TFTP_PORT`=69, and the state enum (IDLE/NAME/LOOKUP/DONE).
- Sub-module `crc32_byte`: combinational next-CRC from (crc_in[31:0], byte[7:0]). The registers stay in `filename_lookup`, which lets the sub-module be reused by the TX path.
- Table compare uses a generate loop with a priority encoder.

## Test plan
- "123456789\0" with `FILE_CRCS[1]`=0xCBF43926 and `FILE_LOCS[1]`=16'h0400 → `done` 2 cycles after the NUL, `hit`=1, `file_index`=1, `mem_location`=16'h0400.
- Same name with no matching entry → `hit`=0, `mem_location`=0, `too_long`=0.
- Entries 0 and 2 both 0xCBF43926 → `file_index`=0.
- `MAX_NAME_LEN`=8, nine non-NUL bytes → `done` the cycle after byte 9, `too_long`=1, `hit`=0.
- Random `en` gaps inside "123456789\0" → same result as gap-free. `dest_port`=69 → `port_ok`=1; 70 → `port_ok`=0.
- `reset` pulsed mid-name → all outputs 0 immediately. A `start` mid-name restarts: only one `done`, for the second name. An empty name → miss.
